// File: rtl/store_merge_unit_pkg.sv
// Shared store-path definitions: size encodings, merge FSM states and lane-width helpers.
package operations;

    localparam logic [1:0] SPL_SB = 2'd0;
    localparam logic [1:0] SPL_SH = 2'd1;
    localparam logic [1:0] SPL_SW = 2'd2;
    localparam logic [1:0] SPL_SD = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } store_merge_state_t;

    function automatic int strb_w(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int off_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_shifter.sv
// Places right-aligned sub-word data into its byte lanes and flags misaligned/illegal sizes.
module lane_shifter
    import operations::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]                size,
    input  logic [off_w(XLEN)-1:0]    off,
    input  logic [XLEN-1:0]           data,
    output logic [XLEN-1:0]           shifted,
    output logic [strb_w(XLEN)-1:0]   bytemask,
    output logic                      misaligned
);

    localparam int MW = strb_w(XLEN);

    logic [XLEN-1:0] data_mask;
    logic [MW-1:0]   base_mask;

    always_comb begin
        data_mask  = '0;
        base_mask  = '0;
        misaligned = 1'b0;
        case (size)
            SPL_SB: begin
                data_mask[7:0] = '1;
                base_mask      = MW'(1);
            end
            SPL_SH: begin
                data_mask[15:0] = '1;
                base_mask       = MW'(3);
                misaligned      = off[0];
            end
            SPL_SW: begin
                data_mask[31:0] = '1;
                base_mask       = MW'(15);
                misaligned      = |off[1:0];
            end
            default: begin
                // A doubleword only exists on a 64-bit datapath.
                if (XLEN == 64) begin
                    data_mask  = '1;
                    base_mask  = '1;
                    misaligned = |off;
                end else begin
                    misaligned = 1'b1;
                end
            end
        endcase
    end

    assign shifted  = (data & data_mask) << {off, 3'b000};
    assign bytemask = base_mask << off;

endmodule

// File: rtl/store_merge_unit.sv
// Sub-word store engine: merges SB/SH/SW/SD into memory words via read-modify-write or strobed writes.
module store_merge_unit
    import operations::*;
#(
    parameter int XLEN      = 64,
    parameter int ADDR_W    = 64,
    parameter int STRB_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_data,
    input  logic [1:0]          req_size,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                mem_wr_en,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic                resp_valid,
    output logic                resp_err
);

    localparam int STRB_W = strb_w(XLEN);
    localparam int OFF_W  = off_w(XLEN);

    store_merge_state_t state;

    logic [1:0]        cap_size;
    logic [OFF_W-1:0]  cap_off;
    logic [XLEN-1:0]   cap_data;

    logic              idle;
    logic [1:0]        ls_size;
    logic [OFF_W-1:0]  ls_off;
    logic [XLEN-1:0]   ls_data;
    logic [XLEN-1:0]   shifted;
    logic [STRB_W-1:0] bytemask;
    logic              misaligned;
    logic [XLEN-1:0]   bit_mask;
    logic [XLEN-1:0]   merged;
    logic              full_write;

    assign idle      = (state == IDLE);
    assign req_ready = idle;

    // One shifter serves both the accept decision (live request) and the merge (captured request).
    assign ls_size = idle ? req_size              : cap_size;
    assign ls_off  = idle ? req_addr[OFF_W-1:0]   : cap_off;
    assign ls_data = idle ? req_data              : cap_data;

    lane_shifter #(.XLEN(XLEN)) u_lane (
        .size       (ls_size),
        .off        (ls_off),
        .data       (ls_data),
        .shifted    (shifted),
        .bytemask   (bytemask),
        .misaligned (misaligned)
    );

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < XLEN; i++) bit_mask[i] = bytemask[i/8];
    end

    assign merged     = (mem_rdata & ~bit_mask) | (shifted & bit_mask);
    assign full_write = (STRB_MODE != 0) || (req_size == SPL_SD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cap_size   <= '0;
            cap_off    <= '0;
            cap_data   <= '0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    cap_size <= req_size;
                    cap_off  <= req_addr[OFF_W-1:0];
                    cap_data <= req_data;
                    mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (misaligned) begin
                        state      <= ERR;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (full_write) begin
                        state     <= WRITE;
                        mem_wr_en <= 1'b1;
                        mem_wdata <= shifted;
                        mem_wstrb <= (STRB_MODE != 0) ? bytemask : '1;
                    end else begin
                        state     <= READ;
                        mem_rd_en <= 1'b1;
                    end
                end
                READ: if (mem_rvalid) begin
                    state     <= WRITE;
                    mem_wr_en <= 1'b1;
                    mem_wdata <= merged;
                    mem_wstrb <= '1;
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Parametrised sub-word store engine between the execute-stage store path and a word-wide data memory.
- Positions SB/SH/SW/SD data into the correct byte lanes of an XLEN-wide word and flags misaligned stores.
- Commits each store either as a read-modify-write (RMW) sequence or, in strobe mode, as a single strobed write.

Parameters:
- XLEN, 64, data/word width in bits; must be 32 or 64.
- ADDR_W, 64, byte-address width.
- STRB_MODE, 0, 0 = RMW through a read then write; 1 = write-only with byte strobes, no read issued.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_data  in  XLEN  store data, right-aligned (LSB-justified).
- req_size  in  2  operations::SPL_SB/SH/SW/SD.
- mem_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wdata  out  XLEN  merged write word.
- mem_wstrb  out  XLEN/8  byte-lane enables; all ones in RMW mode.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = misaligned or illegal size.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - mem_rd_en, mem_wr_en, resp_valid, resp_err, mem_wdata, mem_wstrb, mem_addr all 0.
  - Request capture registers cleared.
- req_ready = (state==IDLE). Requests presented while reset is high are ignored.
- Acceptance: on req_valid && req_ready, latch addr, data, size and compute off = addr[log2(XLEN/8)-1:0].
- Alignment check:
  - SH requires off[0]=0.
  - SW requires off[1:0]=0.
  - SD requires off=0 and XLEN=64; SD with XLEN=32 is illegal.
  - SB is always legal.
- Lane placement: shifted = zero-extended size field << (8*off); byte mask = (1,3,15,255 by size) << off.
- State machine:
  - IDLE: on accept, go to ERR if misaligned/illegal. Otherwise go to WRITE if STRB_MODE=1 or size=SD (full word). Otherwise go to READ.
  - READ: mem_rd_en=1 on the first cycle in READ only; mem_addr held. Wait for mem_rvalid. On mem_rvalid, capture merged = (mem_rdata & ~bytemask) | (shifted & bytemask), then go to WRITE.
  - WRITE: exactly one cycle. mem_wr_en=1; mem_wdata = merged (RMW) or shifted (strobe/SD). mem_wstrb = bytemask in STRB_MODE, else all ones. Then go to RESP.
  - RESP: resp_valid=1, resp_err=0 for one cycle; then IDLE.
  - ERR: resp_valid=1, resp_err=1 for one cycle. No memory strobes in this request; then IDLE.
- Latency from accept edge:
  - resp_valid at cycle 2 on the direct-write path.
  - resp_valid at cycle 1 on the error path.
  - resp_valid at cycle 3+N on the RMW path, where N = cycles from the read strobe to mem_rvalid (N≥0). mem_rvalid in the same cycle as mem_rd_en is legal.
- mem_rvalid outside READ is ignored.
- mem_rdata bytes outside bytemask pass through unchanged.
- req_data bits above the store size are ignored.
- Async reset mid-sequence aborts immediately: no write or response is issued for the in-flight store; the next request starts from IDLE.
- req_valid held during a busy state is not accepted until IDLE. Back-to-back requests therefore have a minimum gap of one RESP cycle.

Decomposition:
- Package operations:
  - SPL_SB/SH/SW/SD encoding (shared with existing store logic).
  - state typedef store_merge_state_t {IDLE, READ, WRITE, RESP, ERR}.
  - Constant function for byte-mask width.
- Sub-module lane_shifter (combinational): given size, off and data, produces shifted data, bytemask and misaligned flag. It is reused by the future load aligner.

Test Plan:
- XLEN=64, STRB_MODE=0; SB addr 0x1003, data 0xFFAB; memory returns 0x1122334455667788 after 2 cycles -> write 0x11223344AB667788, wstrb 0xFF, mem_addr 0x1000; resp_valid at accept+5, resp_err=0.
- SH addr 0x2006, data 0xBEEF; rdata 0x1122334455667788 with rvalid same cycle as rd_en -> write 0xBEEF334455667788; resp at accept+3.
- SW addr 0x3002 -> no mem_rd_en/mem_wr_en ever; resp_valid=1, resp_err=1 at accept+1; req_ready high the next cycle.
- SD addr 0x4000, data 0xDEADBEEFCAFEF00D -> no read; one write of the data, wstrb 0xFF; resp at accept+2. Same test with XLEN=32 -> resp_err=1.
- STRB_MODE=1, SH addr 0x5002, data 0x1234 -> single write, wdata 0x0000000012340000, wstrb 0x0C, no read.
- Assert reset while in READ -> all outputs 0 immediately; a late mem_rvalid is ignored; no resp_valid; the next SB completes normally.
